// File: rtl/wtg_bht_predictor.sv
// wtg_bht_predictor: branch-history-table next-PC predictor; looks up in IF, resolves and trains in EX, keeps branch stats.
// Latency: prediction 1 cycle after lookup; EX resolve combinational; flush/redirect registered 1 cycle after EX.
// Backpressure: none; a lookup and an EX slot are accepted every cycle, and squashing on flush is left to IF.

`ifndef WTG_OP_BIT
`define WTG_OP_BIT 4
`endif
`ifndef WTG_OP_NOP
`define WTG_OP_NOP  4'd0
`endif
`ifndef WTG_OP_J32
`define WTG_OP_J32  4'd1
`endif
`ifndef WTG_OP_J26
`define WTG_OP_J26  4'd2
`endif
`ifndef WTG_OP_BEQ
`define WTG_OP_BEQ  4'd3
`endif
`ifndef WTG_OP_BNE
`define WTG_OP_BNE  4'd4
`endif
`ifndef WTG_OP_BLEZ
`define WTG_OP_BLEZ 4'd5
`endif
`ifndef WTG_OP_BGTZ
`define WTG_OP_BGTZ 4'd6
`endif
`ifndef WTG_OP_BLTZ
`define WTG_OP_BLTZ 4'd7
`endif
`ifndef WTG_OP_BGEZ
`define WTG_OP_BGEZ 4'd8
`endif

module wtg_bht_predictor #(
  parameter int ADDR_WIDTH = 32,
  parameter int BHT_DEPTH  = 64,
  parameter int CTR_BITS   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_valid,
  input  logic [ADDR_WIDTH-1:0]  if_pc,
  output logic                   pred_valid,
  output logic                   pred_taken,
  output logic [ADDR_WIDTH-1:0]  pred_target,
  input  logic                   ex_valid,
  input  logic [ADDR_WIDTH-1:0]  ex_pc,
  input  logic [`WTG_OP_BIT-1:0] ex_op,
  input  logic [31:0]            ex_off32,
  input  logic [25:0]            ex_imm26,
  input  logic [31:0]            ex_data_x,
  input  logic [31:0]            ex_data_y,
  input  logic                   ex_pred_taken,
  input  logic [ADDR_WIDTH-1:0]  ex_pred_target,
  output logic [ADDR_WIDTH-1:0]  ex_pc_new,
  output logic                   ex_branched,
  output logic                   flush,
  output logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic [31:0]            stat_branches,
  output logic [31:0]            stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  // Weakly not-taken: one below the counter midpoint.
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [31:0]         STAT_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic                  valid;
    logic [CTR_BITS-1:0]   ctr;
    logic [ADDR_WIDTH-1:0] target;
  } bht_entry_t;

  bht_entry_t tbl_q [BHT_DEPTH];

  // ---------------- IF-side lookup ----------------
  logic [IDX_W-1:0]      if_idx;
  bht_entry_t            lk_entry;
  logic                  lk_taken;
  logic [ADDR_WIDTH-1:0] lk_target;

  // Untagged table: any PC with the same index bits shares an entry.
  assign if_idx    = if_pc[IDX_W+1:2];
  assign lk_entry  = tbl_q[if_idx];
  assign lk_taken  = lk_entry.valid && lk_entry.ctr[CTR_BITS-1];
  assign lk_target = lk_taken ? lk_entry.target : (if_pc + ADDR_WIDTH'(4));

  // ---------------- EX-side resolve ----------------
  logic [ADDR_WIDTH-1:0] pc_4;
  logic [ADDR_WIDTH-1:0] br_off;
  logic [ADDR_WIDTH-1:0] res_target;
  logic                  res_taken;
  logic                  is_ctrl;
  logic                  is_jump;

  assign pc_4   = ex_pc + ADDR_WIDTH'(4);
  // Word offset scaled to bytes; wraps modulo 2^ADDR_WIDTH when added.
  assign br_off = ADDR_WIDTH'($signed({ex_off32, 2'b00}));

  // Decode the control-transfer op and compute direction and next PC.
  always_comb begin
    res_taken  = 1'b0;
    res_target = pc_4;
    is_ctrl    = 1'b1;
    is_jump    = 1'b0;
    case (ex_op)
      `WTG_OP_J32: begin
        is_jump    = 1'b1;
        res_taken  = 1'b1;
        res_target = ADDR_WIDTH'(ex_data_x);
      end
      `WTG_OP_J26: begin
        is_jump    = 1'b1;
        res_taken  = 1'b1;
        res_target = {pc_4[ADDR_WIDTH-1:28], ex_imm26, 2'b00};
      end
      `WTG_OP_BEQ:  res_taken = (ex_data_x == ex_data_y);
      `WTG_OP_BNE:  res_taken = (ex_data_x != ex_data_y);
      `WTG_OP_BLEZ: res_taken = ($signed(ex_data_x) <= 32'sd0);
      `WTG_OP_BGTZ: res_taken = ($signed(ex_data_x) >  32'sd0);
      `WTG_OP_BLTZ: res_taken = ($signed(ex_data_x) <  32'sd0);
      `WTG_OP_BGEZ: res_taken = ($signed(ex_data_x) >= 32'sd0);
      default:      is_ctrl   = 1'b0;
    endcase
    if (is_ctrl && !is_jump && res_taken) begin
      res_target = pc_4 + br_off;
    end
  end

  assign ex_pc_new   = res_target;
  assign ex_branched = ex_valid && res_taken;

  // A non-control op that was predicted taken also counts: its correct next PC is pc_4.
  logic mispredict;
  assign mispredict = ex_valid &&
                      ((ex_branched != ex_pred_taken) || (ex_pc_new != ex_pred_target));

  // ---------------- Table training ----------------
  logic [IDX_W-1:0] ex_idx;
  logic             upd_en;
  bht_entry_t       upd_entry;

  assign ex_idx = ex_pc[IDX_W+1:2];
  assign upd_en = ex_valid && is_ctrl;

  // Next value of the EX entry: jumps force strongly taken, branches step the counter.
  always_comb begin
    upd_entry = tbl_q[ex_idx];
    if (is_jump) begin
      upd_entry.valid  = 1'b1;
      upd_entry.ctr    = CTR_MAX;
      upd_entry.target = res_target;
    end else if (res_taken) begin
      if (upd_entry.ctr != CTR_MAX) begin
        upd_entry.ctr = upd_entry.ctr + CTR_BITS'(1);
      end
      upd_entry.valid  = 1'b1;
      upd_entry.target = res_target;
    end else begin
      if (upd_entry.ctr != '0) begin
        upd_entry.ctr = upd_entry.ctr - CTR_BITS'(1);
      end
    end
  end

  // Table storage; the lookup reads the old contents in the same cycle as a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        tbl_q[i] <= '{valid: 1'b0, ctr: CTR_INIT, target: '0};
      end
    end else if (upd_en) begin
      tbl_q[ex_idx] <= upd_entry;
    end
  end

  // Prediction register: valid pulses per request, direction/target hold between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else begin
      pred_valid <= if_valid;
      if (if_valid) begin
        pred_taken  <= lk_taken;
        pred_target <= lk_target;
      end
    end
  end

  // One-cycle flush pulse with the corrected PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      flush <= mispredict;
      if (mispredict) begin
        redirect_pc <= ex_pc_new;
      end
    end
  end

  // Saturating branch and mispredict counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd_en && (stat_branches != STAT_MAX)) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (mispredict && (stat_mispredicts != STAT_MAX)) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_wtg_bht_predictor.sv
// tb_wtg_bht_predictor: drives wtg_bht_predictor with directed scenarios and random traffic.
// Reference: table of counters/targets kept as plain arrays, updated from the architectural rules.
// All registered outputs are sampled 1 ns after the rising edge, combinational ones 2 ns after.

`ifndef WTG_OP_BIT
`define WTG_OP_BIT 4
`endif
`ifndef WTG_OP_NOP
`define WTG_OP_NOP  4'd0
`endif
`ifndef WTG_OP_J32
`define WTG_OP_J32  4'd1
`endif
`ifndef WTG_OP_J26
`define WTG_OP_J26  4'd2
`endif
`ifndef WTG_OP_BEQ
`define WTG_OP_BEQ  4'd3
`endif
`ifndef WTG_OP_BNE
`define WTG_OP_BNE  4'd4
`endif
`ifndef WTG_OP_BLEZ
`define WTG_OP_BLEZ 4'd5
`endif
`ifndef WTG_OP_BGTZ
`define WTG_OP_BGTZ 4'd6
`endif
`ifndef WTG_OP_BLTZ
`define WTG_OP_BLTZ 4'd7
`endif
`ifndef WTG_OP_BGEZ
`define WTG_OP_BGEZ 4'd8
`endif

module tb_wtg_bht_predictor;

  localparam int DEPTH    = 64;
  localparam int CTR_MAX  = 3;
  localparam int CTR_INIT = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [3:0]  ex_op;
  logic [31:0] ex_off32;
  logic [25:0] ex_imm26;
  logic [31:0] ex_data_x, ex_data_y;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [31:0] ex_pc_new;
  logic        ex_branched;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches, stat_mispredicts;

  wtg_bht_predictor #(.ADDR_WIDTH(32), .BHT_DEPTH(DEPTH), .CTR_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op(ex_op), .ex_off32(ex_off32),
    .ex_imm26(ex_imm26), .ex_data_x(ex_data_x), .ex_data_y(ex_data_y),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_pc_new(ex_pc_new), .ex_branched(ex_branched),
    .flush(flush), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Reference model state
  bit          m_valid [DEPTH];
  int          m_ctr   [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  logic [31:0] m_stat_b, m_stat_m;
  bit          e_pred_valid, e_pred_taken, e_flush, e_branched;
  logic [31:0] e_pred_target, e_redirect, e_pc_new;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'(DEPTH));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0; m_ctr[i] = CTR_INIT; m_tgt[i] = 32'h0;
    end
    m_stat_b = 0; m_stat_m = 0;
    e_pred_valid = 0; e_pred_taken = 0; e_pred_target = 0;
    e_flush = 0; e_redirect = 0;
  endtask

  task automatic model_lookup(input logic [31:0] pc, output bit tk, output logic [31:0] tgt);
    int i;
    i = idx_of(pc);
    tk = m_valid[i] && (m_ctr[i] > CTR_MAX / 2);
    tgt = tk ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic model_resolve(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] off,
                               input logic [25:0] imm, input logic [31:0] x, input logic [31:0] y,
                               output bit ctrl, output bit jump, output bit tk, output logic [31:0] npc);
    int sx;
    logic [31:0] pc4;
    sx = x;
    pc4 = pc + 32'd4;
    ctrl = 1; jump = 0; tk = 0; npc = pc4;
    case (op)
      `WTG_OP_J32:  begin jump = 1; tk = 1; npc = x; end
      `WTG_OP_J26:  begin jump = 1; tk = 1; npc = (pc4 & 32'hF000_0000) + 32'(imm) * 32'd4; end
      `WTG_OP_BEQ:  tk = (x == y);
      `WTG_OP_BNE:  tk = (x != y);
      `WTG_OP_BLEZ: tk = (sx <= 0);
      `WTG_OP_BGTZ: tk = (sx > 0);
      `WTG_OP_BLTZ: tk = (sx < 0);
      `WTG_OP_BGEZ: tk = (sx >= 0);
      default:      ctrl = 0;
    endcase
    if (ctrl && !jump && tk) npc = pc4 + off * 32'd4;
  endtask

  // Drive one cycle of inputs and advance the model to the state expected after the next edge.
  task automatic apply(input bit ifv, input logic [31:0] ipc, input bit exv, input logic [31:0] epc,
                       input logic [3:0] op, input logic [31:0] off, input logic [25:0] imm,
                       input logic [31:0] x, input logic [31:0] y, input bit pt, input logic [31:0] ptgt);
    bit ctrl, jump, tk, mis, lt;
    logic [31:0] npc, ltgt;
    int i;
    if_valid = ifv; if_pc = ipc; ex_valid = exv; ex_pc = epc; ex_op = op; ex_off32 = off;
    ex_imm26 = imm; ex_data_x = x; ex_data_y = y; ex_pred_taken = pt; ex_pred_target = ptgt;
    e_pred_valid = ifv;
    if (ifv) begin
      model_lookup(ipc, lt, ltgt);
      e_pred_taken = lt; e_pred_target = ltgt;
    end
    model_resolve(op, epc, off, imm, x, y, ctrl, jump, tk, npc);
    e_branched = exv && tk;
    e_pc_new = npc;
    mis = exv && ((e_branched != pt) || (npc != ptgt));
    e_flush = mis;
    if (mis) e_redirect = npc;
    if (exv && ctrl) begin
      if (m_stat_b != 32'hFFFF_FFFF) m_stat_b = m_stat_b + 1;
      i = idx_of(epc);
      if (jump) begin
        m_valid[i] = 1; m_ctr[i] = CTR_MAX; m_tgt[i] = npc;
      end else if (tk) begin
        m_ctr[i] = (m_ctr[i] < CTR_MAX) ? m_ctr[i] + 1 : CTR_MAX;
        m_valid[i] = 1; m_tgt[i] = npc;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end
    if (mis && m_stat_m != 32'hFFFF_FFFF) m_stat_m = m_stat_m + 1;
    #1;
  endtask

  task automatic idle();
    apply(0, 32'h0, 0, 32'h0, `WTG_OP_NOP, 32'h0, 26'h0, 32'h0, 32'h0, 0, 32'h4);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++; if (pred_valid !== 1'b0) begin n_errors++; $display("FAIL reset_pred_valid: got %0b want 0", pred_valid); end
    n_checks++; if (pred_taken !== 1'b0) begin n_errors++; $display("FAIL reset_pred_taken: got %0b want 0", pred_taken); end
    n_checks++; if (pred_target !== 32'h0) begin n_errors++; $display("FAIL reset_pred_target: got %h want 0", pred_target); end
    n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL reset_flush: got %0b want 0", flush); end
    n_checks++; if (redirect_pc !== 32'h0) begin n_errors++; $display("FAIL reset_redirect: got %h want 0", redirect_pc); end
    n_checks++; if (stat_branches !== 32'h0) begin n_errors++; $display("FAIL reset_stat_b: got %0d want 0", stat_branches); end
    n_checks++; if (stat_mispredicts !== 32'h0) begin n_errors++; $display("FAIL reset_stat_m: got %0d want 0", stat_mispredicts); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lookup_basic();
    apply(1, 32'h1000, 0, 32'h0, `WTG_OP_NOP, 32'h0, 26'h0, 32'h0, 32'h0, 0, 32'h4);
    tick();
    n_checks++; if (pred_valid !== 1'b1) begin n_errors++; $display("FAIL lookup_valid: got %0b want 1", pred_valid); end
    n_checks++; if (pred_taken !== 1'b0) begin n_errors++; $display("FAIL lookup_taken: got %0b want 0", pred_taken); end
    n_checks++; if (pred_target !== 32'h1004) begin n_errors++; $display("FAIL lookup_target: got %h want 00001004", pred_target); end
    n_checks++; if (stat_branches !== 0 || stat_mispredicts !== 0) begin n_errors++; $display("FAIL lookup_stats: got %0d/%0d want 0/0", stat_branches, stat_mispredicts); end
    idle();
    tick();
    n_checks++; if (pred_valid !== 1'b0) begin n_errors++; $display("FAIL lookup_idle_valid: got %0b want 0", pred_valid); end
    n_checks++; if (pred_target !== 32'h1004) begin n_errors++; $display("FAIL lookup_hold_target: got %h want 00001004", pred_target); end
  endtask

  task automatic test_beq_train();
    apply(0, 32'h0, 1, 32'h1000, `WTG_OP_BEQ, 32'h10, 26'h0, 32'd10000, 32'd10000, 0, 32'h1004);
    n_checks++; if (ex_pc_new !== 32'h1044) begin n_errors++; $display("FAIL beq_pc_new: got %h want 00001044", ex_pc_new); end
    n_checks++; if (ex_branched !== 1'b1) begin n_errors++; $display("FAIL beq_branched: got %0b want 1", ex_branched); end
    tick();
    n_checks++; if (flush !== 1'b1) begin n_errors++; $display("FAIL beq_flush: got %0b want 1", flush); end
    n_checks++; if (redirect_pc !== 32'h1044) begin n_errors++; $display("FAIL beq_redirect: got %h want 00001044", redirect_pc); end
    n_checks++; if (stat_branches !== 1 || stat_mispredicts !== 1) begin n_errors++; $display("FAIL beq_stats: got %0d/%0d want 1/1", stat_branches, stat_mispredicts); end
    apply(1, 32'h1000, 0, 32'h0, `WTG_OP_NOP, 32'h0, 26'h0, 32'h0, 32'h0, 0, 32'h4);
    tick();
    n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL beq_flush_pulse: got %0b want 0", flush); end
    n_checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h1044) begin n_errors++; $display("FAIL beq_relookup: got %0b/%h want 1/00001044", pred_taken, pred_target); end
    apply(0, 32'h0, 1, 32'h1000, `WTG_OP_BEQ, 32'h10, 26'h0, 32'd10000, 32'd10000, 1, 32'h1044);
    tick();
    n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL beq_correct_no_flush: got %0b want 0", flush); end
    n_checks++; if (stat_branches !== 2 || stat_mispredicts !== 1) begin n_errors++; $display("FAIL beq_stats2: got %0d/%0d want 2/1", stat_branches, stat_mispredicts); end
  endtask

  task automatic test_jumps();
    bit pt;
    logic [31:0] ptgt;
    model_lookup(32'h1000, pt, ptgt);
    apply(0, 32'h0, 1, 32'h1000, `WTG_OP_J26, 32'h0, 26'h8086, 32'h0, 32'h0, pt, ptgt);
    n_checks++; if (ex_pc_new !== e_pc_new || ex_branched !== 1'b1) begin n_errors++; $display("FAIL j26_resolve: got %h/%0b want %h/1", ex_pc_new, ex_branched, e_pc_new); end
    tick();
    n_checks++; if (flush !== e_flush) begin n_errors++; $display("FAIL j26_flush: got %0b want %0b", flush, e_flush); end
    apply(1, 32'h1000, 0, 32'h0, `WTG_OP_NOP, 32'h0, 26'h0, 32'h0, 32'h0, 0, 32'h4);
    tick();
    n_checks++; if (pred_taken !== 1'b1 || pred_target !== e_pred_target) begin n_errors++; $display("FAIL j26_relookup: got %0b/%h want 1/%h", pred_taken, pred_target, e_pred_target); end
    apply(0, 32'h0, 1, 32'h2004, `WTG_OP_J32, 32'h0, 26'h0, 32'h8000_1000, 32'h0, 0, 32'h2008);
    n_checks++; if (ex_pc_new !== 32'h8000_1000 || ex_branched !== 1'b1) begin n_errors++; $display("FAIL j32_resolve: got %h/%0b want 80001000/1", ex_pc_new, ex_branched); end
    tick();
    n_checks++; if (flush !== 1'b1 || redirect_pc !== 32'h8000_1000) begin n_errors++; $display("FAIL j32_flush: got %0b/%h want 1/80001000", flush, redirect_pc); end
    apply(1, 32'h2004, 0, 32'h0, `WTG_OP_NOP, 32'h0, 26'h0, 32'h0, 32'h0, 0, 32'h4);
    tick();
    n_checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h8000_1000) begin n_errors++; $display("FAIL j32_relookup: got %0b/%h want 1/80001000", pred_taken, pred_target); end
  endtask

  task automatic test_sign_boundaries();
    logic [3:0]  ops [10] = '{`WTG_OP_BLTZ, `WTG_OP_BLTZ, `WTG_OP_BLTZ, `WTG_OP_BLEZ, `WTG_OP_BLEZ,
                              `WTG_OP_BGTZ, `WTG_OP_BGTZ, `WTG_OP_BGEZ, `WTG_OP_BGEZ, `WTG_OP_BLEZ};
    logic [31:0] xs  [10] = '{32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0, 32'h1,
                              32'h0, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000};
    bit          want[10] = '{1, 0, 0, 1, 0, 0, 1, 1, 0, 1};
    bit pt;
    logic [31:0] ptgt, pc;
    for (int i = 0; i < 10; i++) begin
      pc = 32'h3008 + 32'(i) * 32'd4;
      model_lookup(pc, pt, ptgt);
      apply(0, 32'h0, 1, pc, ops[i], 32'h20, 26'h0, xs[i], 32'h0, pt, ptgt);
      n_checks++; if (ex_branched !== want[i]) begin n_errors++; $display("FAIL sign_case%0d_branched: got %0b want %0b", i, ex_branched, want[i]); end
      n_checks++; if (ex_pc_new !== e_pc_new) begin n_errors++; $display("FAIL sign_case%0d_pc_new: got %h want %h", i, ex_pc_new, e_pc_new); end
      tick();
      n_checks++; if (flush !== e_flush) begin n_errors++; $display("FAIL sign_case%0d_flush: got %0b want %0b", i, flush, e_flush); end
    end
  endtask

  task automatic test_saturation();
    bit pt;
    logic [31:0] ptgt;
    for (int i = 0; i < 5; i++) begin
      model_lookup(32'h4040, pt, ptgt);
      apply(0, 32'h0, 1, 32'h4040, `WTG_OP_BNE, 32'h2, 26'h0, 32'd1, 32'd2, pt, ptgt);
      tick();
    end
    model_lookup(32'h4040, pt, ptgt);
    apply(0, 32'h0, 1, 32'h4040, `WTG_OP_BNE, 32'h2, 26'h0, 32'd1, 32'd1, pt, ptgt);
    tick();
    n_checks++; if (stat_mispredicts !== m_stat_m) begin n_errors++; $display("FAIL sat_mispredicts: got %0d want %0d", stat_mispredicts, m_stat_m); end
    n_checks++; if (stat_branches !== m_stat_b) begin n_errors++; $display("FAIL sat_branches: got %0d want %0d", stat_branches, m_stat_b); end
    // Second not-taken while looking up the same index: the lookup must see the pre-update counter.
    apply(1, 32'h4040, 1, 32'h4040, `WTG_OP_BNE, 32'h2, 26'h0, 32'd1, 32'd1, 1, 32'h404C);
    tick();
    n_checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h404C) begin n_errors++; $display("FAIL sat_rbw_lookup: got %0b/%h want 1/0000404c", pred_taken, pred_target); end
    n_checks++; if (flush !== 1'b1 || redirect_pc !== 32'h4044) begin n_errors++; $display("FAIL sat_rbw_flush: got %0b/%h want 1/00004044", flush, redirect_pc); end
    apply(1, 32'h4040, 0, 32'h0, `WTG_OP_NOP, 32'h0, 26'h0, 32'h0, 32'h0, 0, 32'h4);
    tick();
    n_checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h4044) begin n_errors++; $display("FAIL sat_after_two_not: got %0b/%h want 0/00004044", pred_taken, pred_target); end
  endtask

  task automatic test_back_to_back();
    apply(0, 32'h0, 1, 32'h7000, `WTG_OP_BEQ, 32'h3, 26'h0, 32'd5, 32'd5, 0, 32'h7004);
    tick();
    n_checks++; if (flush !== 1'b1 || redirect_pc !== 32'h7010) begin n_errors++; $display("FAIL b2b_first: got %0b/%h want 1/00007010", flush, redirect_pc); end
    apply(0, 32'h0, 1, 32'h7004, `WTG_OP_J32, 32'h0, 26'h0, 32'h1234, 32'h0, 0, 32'h7008);
    tick();
    n_checks++; if (flush !== 1'b1 || redirect_pc !== 32'h1234) begin n_errors++; $display("FAIL b2b_second: got %0b/%h want 1/00001234", flush, redirect_pc); end
    // A plain op carrying a taken prediction must redirect to its fall-through.
    apply(0, 32'h0, 1, 32'h7100, `WTG_OP_NOP, 32'h0, 26'h0, 32'h0, 32'h0, 1, 32'h9000);
    n_checks++; if (ex_branched !== 1'b0 || ex_pc_new !== 32'h7104) begin n_errors++; $display("FAIL nonctrl_resolve: got %0b/%h want 0/00007104", ex_branched, ex_pc_new); end
    tick();
    n_checks++; if (flush !== 1'b1 || redirect_pc !== 32'h7104) begin n_errors++; $display("FAIL nonctrl_flush: got %0b/%h want 1/00007104", flush, redirect_pc); end
    idle();
    tick();
    n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL b2b_end: got %0b want 0", flush); end
    n_checks++; if (stat_branches !== m_stat_b || stat_mispredicts !== m_stat_m) begin n_errors++; $display("FAIL b2b_stats: got %0d/%0d want %0d/%0d", stat_branches, stat_mispredicts, m_stat_b, m_stat_m); end
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 2))
      0:       return 32'h6000 + 32'd4 * $urandom_range(0, 7);
      1:       return 32'h6100 + 32'd4 * $urandom_range(0, 7);
      default: return 32'hFFFF_FFE0 + 32'd4 * $urandom_range(0, 7);
    endcase
  endfunction

  task automatic test_random();
    bit ifv, exv, pt;
    logic [31:0] ipc, epc, off, x, y, ptgt;
    logic [3:0] op;
    int v;
    for (int c = 0; c < 400; c++) begin
      ifv = 1'($urandom_range(0, 1));
      ipc = pick_pc();
      exv = ($urandom_range(0, 7) != 0);
      epc = pick_pc();
      op  = 4'($urandom_range(0, 9));
      v = int'($urandom_range(0, 4)) - 2; x = v;
      v = int'($urandom_range(0, 4)) - 2; y = v;
      if ($urandom_range(0, 7) == 0) x = $urandom;
      if ($urandom_range(0, 1) == 0) begin v = int'($urandom_range(0, 64)) - 32; off = v; end
      else off = $urandom;
      if ($urandom_range(0, 3) != 0) model_lookup(epc, pt, ptgt);
      else begin pt = 1'($urandom_range(0, 1)); ptgt = pt ? $urandom : epc + 32'd4; end
      apply(ifv, ipc, exv, epc, op, off, 26'($urandom), x, y, pt, ptgt);
      n_checks++; if (ex_pc_new !== e_pc_new) begin n_errors++; $display("FAIL rnd%0d_pc_new: got %h want %h", c, ex_pc_new, e_pc_new); end
      n_checks++; if (ex_branched !== e_branched) begin n_errors++; $display("FAIL rnd%0d_branched: got %0b want %0b", c, ex_branched, e_branched); end
      tick();
      n_checks++; if (pred_valid !== e_pred_valid) begin n_errors++; $display("FAIL rnd%0d_pred_valid: got %0b want %0b", c, pred_valid, e_pred_valid); end
      n_checks++; if (pred_taken !== e_pred_taken || pred_target !== e_pred_target) begin n_errors++; $display("FAIL rnd%0d_pred: got %0b/%h want %0b/%h", c, pred_taken, pred_target, e_pred_taken, e_pred_target); end
      n_checks++; if (flush !== e_flush) begin n_errors++; $display("FAIL rnd%0d_flush: got %0b want %0b", c, flush, e_flush); end
      if (e_flush) begin
        n_checks++; if (redirect_pc !== e_redirect) begin n_errors++; $display("FAIL rnd%0d_redirect: got %h want %h", c, redirect_pc, e_redirect); end
      end
      n_checks++; if (stat_branches !== m_stat_b || stat_mispredicts !== m_stat_m) begin n_errors++; $display("FAIL rnd%0d_stats: got %0d/%0d want %0d/%0d", c, stat_branches, stat_mispredicts, m_stat_b, m_stat_m); end
    end
  endtask

  task automatic test_reset_mid();
    apply(1, 32'h4040, 1, 32'h5080, `WTG_OP_BEQ, 32'h1, 26'h0, 32'd7, 32'd7, 0, 32'h5084);
    tick();
    n_checks++; if (flush !== 1'b1) begin n_errors++; $display("FAIL rstmid_pending_flush: got %0b want 1", flush); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL rstmid_flush: got %0b want 0", flush); end
    n_checks++; if (pred_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_pred_valid: got %0b want 0", pred_valid); end
    n_checks++; if (stat_branches !== 0 || stat_mispredicts !== 0) begin n_errors++; $display("FAIL rstmid_stats: got %0d/%0d want 0/0", stat_branches, stat_mispredicts); end
    model_reset();
    idle();
    rst_n = 1'b1;
    tick();
    apply(1, 32'h2004, 0, 32'h0, `WTG_OP_NOP, 32'h0, 26'h0, 32'h0, 32'h0, 0, 32'h4);
    tick();
    n_checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h2008) begin n_errors++; $display("FAIL rstmid_table_cleared: got %0b/%h want 0/00002008", pred_taken, pred_target); end
    n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL rstmid_no_flush: got %0b want 0", flush); end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0;
    if_valid = 0; if_pc = 0; ex_valid = 0; ex_pc = 0; ex_op = `WTG_OP_NOP; ex_off32 = 0;
    ex_imm26 = 0; ex_data_x = 0; ex_data_y = 0; ex_pred_taken = 0; ex_pred_target = 0;
    model_reset();
    #12;
    test_reset();
    test_lookup_basic();
    test_beq_train();
    test_jumps();
    test_sign_boundaries();
    test_saturation();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
